// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Used by dmem_bank and dmem_responder. Optional feature macro (set at build time):
// DMEM_RSP_ERRCHK_EN, which enables address error checking in dmem_responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Width of a word index into a DEPTH_WORDS-deep array.
  function automatic int unsigned idx_width(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: word array with a byte-enabled synchronous write and a combinational read.
// Ports:
//   clk_i   - clock, rising edge
//   we_i    - write strobe for the word at idx_i
//   idx_i   - word index shared by read and write
//   wdata_i - write data
//   be_i    - byte enables; bit i writes byte [8i+7:8i]
//   rdata_o - current contents of the word at idx_i
// The array has no reset.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IdxW = idx_width(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IdxW-1:0]   idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the data-memory port. Accepts one load or store
// at a time, waits WAIT_CYCLES cycles, performs the access and holds the response until
// the requester takes it.
// Ports:
//   clk_i, rst_ni            - clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o  - request handshake
//   req_we_i                 - 1 = store, 0 = load
//   req_addr_i               - byte address
//   req_wdata_i, req_be_i    - store data and byte enables
//   rsp_valid_o/rsp_ready_i  - response handshake
//   rsp_rdata_o              - load data; 0 for stores and errors
//   rsp_err_o                - request rejected (only with DMEM_RSP_ERRCHK_EN)
// Build macro DMEM_RSP_ERRCHK_EN: misaligned or out-of-range requests return rsp_err_o=1
// with no write. Without it rsp_err_o is 0, addr[1:0] is ignored and the index wraps.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [WORD_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned IdxW    = idx_width(DEPTH_WORDS);
  localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept, do_access;
  logic              acc_we, acc_err;
  logic [WORD_W-1:0] acc_addr, acc_wdata, bank_rdata;
  logic [BE_W-1:0]   acc_be;
  logic [IdxW-1:0]   acc_idx;

  assign accept = (state_q == IDLE) && req_valid_i;

  // With zero wait states the access happens on the accept edge, so it must use the live
  // request; in every other case the latched copy is the one that counts.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_be_i;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign do_access = (accept && (WAIT_CYCLES == 0)) || ((state_q == WAIT) && (cnt_q == '0));
  assign acc_idx   = acc_addr[IdxW+1:2];

`ifdef DMEM_RSP_ERRCHK_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[WORD_W-1:IdxW+2] != '0);
`else
  assign acc_err = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{acc_addr[WORD_W-1:IdxW+2], acc_addr[1:0]};
`endif

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk_i  (clk_i),
    .we_i   (do_access && acc_we && !acc_err),
    .idx_i  (acc_idx),
    .wdata_i(acc_wdata),
    .be_i   (acc_be),
    .rdata_o(bank_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CntInit;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (!acc_we && !acc_err) ? bank_rdata : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized traffic, all
// compared cycle by cycle against a transaction-level model of the memory.
module tb_dmem_responder;

  localparam int unsigned Depth  = 256;
  localparam int unsigned TbWait = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_valid0, req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(TbWait)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  // Zero-wait-state instance, used for the throughput case only.
  dmem_responder #(.DEPTH_WORDS(4), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(1'b0),
    .req_addr_i(32'h0), .req_wdata_i(32'h0), .req_be_i(4'h0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(1'b1),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl_mem [Depth];
  bit          pend = 1'b0, committed = 1'b0, vexp;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        m_err;
  int          cyc = 0, m_due = 0, acc_cyc = 0, hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit model_err(input logic [31:0] a);
`ifdef DMEM_RSP_ERRCHK_EN
    return (a % 4 != 0) || (a >= 4 * Depth);
`else
    return (a === 32'hx);
`endif
  endfunction

  task automatic model_commit();
    int unsigned idx;
    idx     = (m_addr / 4) % Depth;
    m_err   = model_err(m_addr);
    m_rdata = 32'h0;
    if (!m_err) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++) if (m_be[b]) mdl_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
      end else begin
        m_rdata = mdl_mem[idx];
      end
    end
  endtask

  // Compare process: runs every cycle at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      chk("reset req_ready", req_ready, 32'd1);
      chk("reset rsp_valid", rsp_valid, 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset rsp_err", rsp_err, 32'd0);
    end else begin
      if (pend && !committed && cyc >= m_due) begin
        model_commit();
        committed = 1'b1;
      end
      vexp = pend && committed;
      chk("req_ready", req_ready, !pend);
      chk("rsp_valid", rsp_valid, vexp);
      if (vexp) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
        if (rsp_ready) begin
          pend   = 1'b0;
          hs_cyc = cyc + 1;
        end
      end else if (!pend && req_valid) begin
        pend      = 1'b1;
        committed = 1'b0;
        m_we      = req_we;
        m_addr    = req_addr;
        m_wdata   = req_wdata;
        m_be      = req_be;
        acc_cyc   = cyc + 1;
        m_due     = cyc + 1 + TbWait;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold, input bit early,
                      input logic [31:0] naddr, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    bit acc;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = (hold == 0);
    n = 0; acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) chk("accept timeout", 32'd0, 32'd1);
    // Scramble the request lines after accept; they must not matter any more.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) chk("response timeout", 32'd0, 32'd1);
    rd = rsp_rdata; er = rsp_err;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (early && i == 0) begin
          req_valid = 1'b1; req_we = 1'b0; req_addr = naddr;
        end
        @(negedge clk);
        chk("hold rsp_valid", rsp_valid, 32'd1);
        chk("hold rsp_rdata", rsp_rdata, rd);
        if (early) chk("hold blocks request", req_ready, 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd, w, a;
  logic        er;
  int          lat, hs_prev, prev, nacc;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b0; req_valid0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init req_ready", req_ready, 32'd1);
    chk("init rsp_valid", rsp_valid, 32'd0);
    rst_n = 1'b1;

    // Fill the whole array so every later load has a known answer.
    for (int i = 0; i < Depth; i++) begin
      w = $urandom;
      if (i == 0) w = 32'h0BAD_F00D;
      if (i == 4) w = 32'h1122_3344;
      if (i == 8) w = 32'hCAFE_0020;
      xact(1'b1, 32'(i * 4), w, 4'hF, 0, 1'b0, 32'h0, rd, er, lat);
    end

    // Load at 0 with latency check.
    xact(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, er, lat);
    chk("load0 latency", lat, TbWait);
    chk("load0 rdata", rd, 32'h0BAD_F00D);
    chk("load0 err", er, 32'd0);

    // Partial store then read back.
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0101, 0, 1'b0, 32'h0, rd, er, lat);
    chk("store rdata", rd, 32'h0);
    chk("store err", er, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, 32'h0, rd, er, lat);
    chk("merge rdata", rd, 32'h11AD_33EF);
    chk("merge err", er, 32'd0);

    // Back-pressure with a queued request.
    xact(1'b0, 32'h20, 32'h0, 4'h0, 5, 1'b1, 32'h0, rd, er, lat);
    chk("bp rdata", rd, 32'hCAFE_0020);
    hs_prev = hs_cyc;
    xact(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, er, lat);
    chk("turnaround cycle", acc_cyc, hs_prev + 1);
    chk("queued load rdata", rd, 32'h0BAD_F00D);

`ifdef DMEM_RSP_ERRCHK_EN
    xact(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0, rd, er, lat);
    chk("misaligned err", er, 32'd1);
    chk("misaligned rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, er, lat);
    chk("no write on err", rd, 32'h11AD_33EF);
    xact(1'b0, 32'(4 * Depth), 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, er, lat);
    chk("range err", er, 32'd1);
    chk("range rdata", rd, 32'h0);
`else
    xact(1'b0, 32'(4 * Depth), 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, er, lat);
    chk("wrap rdata", rd, 32'h0BAD_F00D);
    chk("wrap err", er, 32'd0);
`endif

    // Reset while a store to 0x20 sits in WAIT.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("store in wait", req_ready, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async rst req_ready", req_ready, 32'd1);
    chk("async rst rsp_valid", rsp_valid, 32'd0);
    chk("async rst rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, er, lat);
    chk("dropped store", rd, 32'hCAFE_0020);

    // Zero-wait throughput: one accept every two cycles.
    req_valid0 = 1'b1;
    prev = -1; nacc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready0) begin
        if (prev >= 0) chk("w0 accept spacing", 32'(cyc + 1 - prev), 32'd2);
        prev = cyc + 1;
        nacc++;
      end else begin
        chk("w0 rsp_valid", rsp_valid0, 32'd1);
        chk("w0 rsp_err", rsp_err0, 32'd0);
      end
    end
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("w0 accepts", nacc, 32'd6);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 150; i++) begin
      case ($urandom % 8)
        0:       a = $urandom;
        1:       a = 32'(($urandom % Depth) * 4 + 1 + $urandom % 3);
        default: a = 32'(($urandom % Depth) * 4);
      endcase
      xact(1'($urandom), a, $urandom, 4'($urandom), int'($urandom % 4), 1'b0, 32'h0,
           rd, er, lat);
      chk("rand latency", lat, TbWait);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  logic unused_tb;
  assign unused_tb = ^rsp_rdata0;

endmodule
